// File: rtl/jg_pkg.sv
`default_nettype none
// ============================================================================
// jg_pkg : shared types and the uniform-sample (all-zeros/all-ones) test
// Revision: 1.0
// ============================================================================
package jg_pkg;

   typedef enum logic [0:0] {JG_COLLECT = 1'b0, JG_REPORT = 1'b1} jg_state_t;

   localparam int JG_MAX_W = 32;

   // Only bits [w-1:0] of v are meaningful; callers zero-extend narrower samples.
   function automatic logic jg_is_uniform(input logic [JG_MAX_W-1:0] v, input int unsigned w);
      logic uni;
      uni = 1'b1;
      for (int unsigned i = 1; i < JG_MAX_W; i++) begin
         if (i < w && v[i] != v[0]) uni = 1'b0;
      end
      return uni;
   endfunction

endpackage
`default_nettype wire

// File: rtl/jg_window_judge_sample_judge.sv
`default_nettype none
// ============================================================================
// jg_sample_judge : combinational X (>= THRESH) and Y (uniform) judge of one sample
// Revision: 1.0
// ============================================================================
module jg_sample_judge
   import jg_pkg::*;
#(
   parameter int W      = 3,
   parameter int THRESH = 5
) (
   input  logic [W-1:0] sample,
   output logic         x_flag,
   output logic         y_flag
);

   localparam logic [W-1:0] C_THRESH = THRESH[W-1:0];

   logic [JG_MAX_W-1:0] sample_ext;

   always_comb begin
      sample_ext        = '0;
      sample_ext[W-1:0] = sample;
   end

   assign x_flag = (sample >= C_THRESH);
   assign y_flag = jg_is_uniform(sample_ext, W);

endmodule
`default_nettype wire

// File: rtl/jg_window_judge.sv
`default_nettype none
// ============================================================================
// jg_window_judge : per-sample X/Y judge with windowed hit counts and Y-run alarm
// Optional build macro JG_STICKY_ALARM_EN holds run_alarm until the next report handshake.
// Revision: 1.0
// ============================================================================
module jg_window_judge
   import jg_pkg::*;
#(
   parameter int W       = 3,
   parameter int THRESH  = 5,
   parameter int WIN     = 8,
   parameter int RUN_LEN = 3
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [W-1:0]               in_data,
   output logic                       x,
   output logic                       y,
   output logic                       flag_vld,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [$clog2(WIN+1)-1:0]   x_cnt,
   output logic [$clog2(WIN+1)-1:0]   y_cnt,
   output logic                       run_alarm
);

   localparam int CW = $clog2(WIN + 1);
   localparam int RW = $clog2(RUN_LEN + 1);
   localparam logic [CW-1:0] C_LAST    = CW'(WIN - 1);
   localparam logic [RW-1:0] C_RUN_MAX = RW'(RUN_LEN);

   jg_state_t state_q, state_d;

   logic          x_w, y_w;
   logic          accept, handshake, win_done;

   logic [CW-1:0] sample_cnt_q, sample_cnt_d;
   logic [CW-1:0] x_acc_q, x_acc_d, y_acc_q, y_acc_d;
   logic [CW-1:0] x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d;
   logic [RW-1:0] run_q, run_d;
   logic          x_q, x_d, y_q, y_d, flag_vld_q, flag_vld_d;
   logic          out_valid_q, out_valid_d, alarm_q, alarm_d;

   jg_sample_judge #(.W(W), .THRESH(THRESH)) u_judge (
      .sample (in_data),
      .x_flag (x_w),
      .y_flag (y_w)
   );

   assign accept    = in_valid & in_ready;
   assign handshake = out_valid_q & out_ready;
   assign win_done  = accept && (sample_cnt_q == C_LAST);

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (rst) state_q <= JG_COLLECT;
      else     state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         JG_COLLECT: if (win_done)  state_d = JG_REPORT;
         JG_REPORT:  if (handshake) state_d = JG_COLLECT;
         default:                   state_d = JG_COLLECT;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      in_ready = (state_q == JG_COLLECT);
   end

   // ---------------- datapath next values ----------------
   always_comb begin
      sample_cnt_d = sample_cnt_q;
      x_acc_d      = x_acc_q;
      y_acc_d      = y_acc_q;
      x_cnt_d      = x_cnt_q;
      y_cnt_d      = y_cnt_q;
      run_d        = run_q;
      x_d          = x_q;
      y_d          = y_q;
      flag_vld_d   = 1'b0;
      out_valid_d  = out_valid_q;
      alarm_d      = alarm_q;

      if (accept) begin
         x_d        = x_w;
         y_d        = y_w;
         flag_vld_d = 1'b1;
         if (!y_w)                   run_d = '0;
         else if (run_q != C_RUN_MAX) run_d = run_q + 1'b1;

         if (win_done) begin
            // The completing sample is folded into the report, not the next window.
            x_cnt_d      = x_acc_q + CW'(x_w);
            y_cnt_d      = y_acc_q + CW'(y_w);
            x_acc_d      = '0;
            y_acc_d      = '0;
            sample_cnt_d = '0;
            out_valid_d  = 1'b1;
         end else begin
            x_acc_d      = x_acc_q + CW'(x_w);
            y_acc_d      = y_acc_q + CW'(y_w);
            sample_cnt_d = sample_cnt_q + 1'b1;
         end
      end

      if (handshake) out_valid_d = 1'b0;

`ifdef JG_STICKY_ALARM_EN
      if (accept && run_d == C_RUN_MAX) alarm_d = 1'b1;
      else if (handshake)               alarm_d = 1'b0;
`else
      if (accept) alarm_d = (run_d == C_RUN_MAX);
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sample_cnt_q <= '0;
         x_acc_q      <= '0;
         y_acc_q      <= '0;
         x_cnt_q      <= '0;
         y_cnt_q      <= '0;
         run_q        <= '0;
         x_q          <= 1'b0;
         y_q          <= 1'b0;
         flag_vld_q   <= 1'b0;
         out_valid_q  <= 1'b0;
         alarm_q      <= 1'b0;
      end else begin
         sample_cnt_q <= sample_cnt_d;
         x_acc_q      <= x_acc_d;
         y_acc_q      <= y_acc_d;
         x_cnt_q      <= x_cnt_d;
         y_cnt_q      <= y_cnt_d;
         run_q        <= run_d;
         x_q          <= x_d;
         y_q          <= y_d;
         flag_vld_q   <= flag_vld_d;
         out_valid_q  <= out_valid_d;
         alarm_q      <= alarm_d;
      end
   end

   assign x         = x_q;
   assign y         = y_q;
   assign flag_vld  = flag_vld_q;
   assign out_valid = out_valid_q;
   assign x_cnt     = x_cnt_q;
   assign y_cnt     = y_cnt_q;
   assign run_alarm = alarm_q;

endmodule
`default_nettype wire

// File: tb/tb_jg_window_judge.sv
`default_nettype none
// ============================================================================
// tb_jg_window_judge : scoreboard bench for jg_window_judge (honours JG_STICKY_ALARM_EN)
// Revision: 1.0
// ============================================================================
module tb_jg_window_judge;

   localparam int W       = 3;
   localparam int THRESH  = 5;
   localparam int WIN     = 8;
   localparam int RUN_LEN = 3;
   localparam int CW      = $clog2(WIN + 1);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0, out_ready = 1'b0;
   logic [W-1:0]  in_data = '0;
   logic          in_ready, x, y, flag_vld, out_valid, run_alarm;
   logic [CW-1:0] x_cnt, y_cnt;

   logic          in_valid5 = 1'b0, out_ready5 = 1'b0;
   logic [3:0]    in_data5 = '0;
   logic          in_ready5, x5, y5, flag_vld5, out_valid5, run_alarm5;
   logic [0:0]    x_cnt5, y_cnt5;

   always #5 clk = ~clk;

   jg_window_judge #(.W(W), .THRESH(THRESH), .WIN(WIN), .RUN_LEN(RUN_LEN)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .x(x), .y(y), .flag_vld(flag_vld), .out_valid(out_valid), .out_ready(out_ready),
      .x_cnt(x_cnt), .y_cnt(y_cnt), .run_alarm(run_alarm)
   );

   jg_window_judge #(.W(4), .THRESH(0), .WIN(1), .RUN_LEN(1)) u_dut5 (
      .clk(clk), .rst(rst), .in_valid(in_valid5), .in_ready(in_ready5), .in_data(in_data5),
      .x(x5), .y(y5), .flag_vld(flag_vld5), .out_valid(out_valid5), .out_ready(out_ready5),
      .x_cnt(x_cnt5), .y_cnt(y_cnt5), .run_alarm(run_alarm5)
   );

`ifdef JG_STICKY_ALARM_EN
   localparam bit STICKY = 1'b1;
`else
   localparam bit STICKY = 1'b0;
`endif

   int n_checks = 0;
   int n_err    = 0;

   typedef struct {bit x; bit y; bit a;} flag_t;
   typedef struct {int xc; int yc;} rep_t;
   flag_t fq[$];
   rep_t  rq[$];

   // Reference model state: a window is a list of judged samples and a "waiting for consumer" bit.
   bit m_reporting = 1'b0;
   int m_n = 0, m_xa = 0, m_ya = 0, m_run = 0;
   bit m_alarm = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_reporting = 1'b0;
      m_n = 0; m_xa = 0; m_ya = 0; m_run = 0;
      m_alarm = 1'b0;
   endtask

   // One clock of stimulus; level outputs are checked against the model first.
   task automatic cycle(input bit v, input logic [W-1:0] d, input bit ordy, output bit acc);
      bit ex, ey;
      @(negedge clk);
      chk("in_ready", in_ready, !m_reporting);
      chk("run_alarm_level", run_alarm, m_alarm);
      in_valid  = v;
      in_data   = d;
      out_ready = ordy;
      acc = v && !m_reporting;
      if (m_reporting && ordy) begin
         m_reporting = 1'b0;
         if (STICKY) m_alarm = 1'b0;
      end else if (acc) begin
         ex = (int'(d) >= THRESH);
         ey = (int'(d) == 0) || (int'(d) == (1 << W) - 1);
         m_run = ey ? ((m_run + 1 > RUN_LEN) ? RUN_LEN : m_run + 1) : 0;
         if (STICKY) m_alarm = m_alarm | (m_run == RUN_LEN);
         else        m_alarm = (m_run == RUN_LEN);
         fq.push_back('{x: ex, y: ey, a: m_alarm});
         m_xa += int'(ex);
         m_ya += int'(ey);
         m_n++;
         if (m_n == WIN) begin
            rq.push_back('{xc: m_xa, yc: m_ya});
            m_n = 0; m_xa = 0; m_ya = 0;
            m_reporting = 1'b1;
         end
      end
   endtask

   task automatic chk_reset_outputs();
      chk("rst_x", x, 0);
      chk("rst_y", y, 0);
      chk("rst_flag_vld", flag_vld, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_x_cnt", x_cnt, 0);
      chk("rst_y_cnt", y_cnt, 0);
      chk("rst_run_alarm", run_alarm, 0);
      chk("rst_in_ready", in_ready, 1);
   endtask

   // Monitor: pops expected flags / reports whenever the DUT presents them.
   bit   seen = 1'b0;
   rep_t held;
   initial begin
      flag_t f;
      forever begin
         @(posedge clk);
         #1;
         if (!rst) begin
            if (flag_vld) begin
               if (fq.size() == 0) chk("flag_unexpected", 1, 0);
               else begin
                  f = fq.pop_front();
                  chk("flag_x", x, f.x);
                  chk("flag_y", y, f.y);
                  chk("flag_alarm", run_alarm, f.a);
               end
            end
            if (out_valid) begin
               if (!seen) begin
                  if (rq.size() == 0) chk("report_unexpected", 1, 0);
                  else begin
                     held = rq.pop_front();
                     chk("rep_x_cnt", x_cnt, held.xc);
                     chk("rep_y_cnt", y_cnt, held.yc);
                  end
                  seen = 1'b1;
               end else begin
                  chk("hold_x_cnt", x_cnt, held.xc);
                  chk("hold_y_cnt", y_cnt, held.yc);
               end
            end else begin
               seen = 1'b0;
            end
         end
      end
   end

   initial begin
      bit acc;
      int total, cyc;
      logic [W-1:0] d;

      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk_reset_outputs();
      chk("rst5_in_ready", in_ready5, 1);
      chk("rst5_out_valid", out_valid5, 0);

      // WIN=1, THRESH=0 instance: every accept is a full report.
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         in_valid5  = 1'b1;
         in_data5   = (k == 2) ? 4'h5 : 4'hF;
         out_ready5 = 1'b1;
         @(posedge clk); #1;
         chk("w1_out_valid", out_valid5, 1);
         chk("w1_x_cnt", x_cnt5, 1);
         chk("w1_y_cnt", y_cnt5, (k == 2) ? 0 : 1);
         chk("w1_flag_vld", flag_vld5, 1);
         chk("w1_x", x5, 1);
         chk("w1_alarm", run_alarm5, (k == 2) ? 0 : 1);
         chk("w1_in_ready_rep", in_ready5, 0);
         @(posedge clk); #1;
         chk("w1_out_valid_clr", out_valid5, 0);
         chk("w1_in_ready_back", in_ready5, 1);
      end
      @(negedge clk);
      in_valid5 = 1'b0;

      // Samples 0..7 back-to-back, then consumer stalls for 5 cycles.
      for (int i = 0; i < 8; i++) cycle(1'b1, W'(i), 1'b0, acc);
      for (int i = 0; i < 5; i++) begin
         cycle(1'b1, W'(3), 1'b0, acc);
         chk("t2_out_valid", out_valid, 1);
         chk("t2_x_cnt", x_cnt, 3);
         chk("t2_y_cnt", y_cnt, 2);
         chk("t2_in_ready", in_ready, 0);
      end
      cycle(1'b1, W'(3), 1'b1, acc);
      cycle(1'b1, W'(3), 1'b1, acc);
      chk("t2_resume", in_ready, 1);

      // Y run 7,0,7 then a non-Y sample.
      cycle(1'b1, W'(7), 1'b1, acc);
      cycle(1'b1, W'(0), 1'b1, acc);
      cycle(1'b1, W'(7), 1'b1, acc);
      cycle(1'b1, W'(2), 1'b1, acc);
      chk("t3_alarm_set", run_alarm, 1);
      cycle(1'b0, W'(2), 1'b1, acc);
      chk("t3_alarm_after_2", run_alarm, STICKY ? 1 : 0);

      // Align to a window start, feed 4 samples, then reset mid-window.
      cyc = 0;
      while ((m_n != 0 || m_reporting) && cyc < 100) begin
         cycle(1'b1, W'($urandom), 1'b1, acc);
         cyc++;
      end
      for (int i = 0; i < 4; i++) cycle(1'b1, W'(7 - i), 1'b1, acc);
      @(negedge clk);
      rst = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      chk_reset_outputs();
      for (int i = 0; i < 8; i++) cycle(1'b1, W'(3), 1'b0, acc);
      cycle(1'b0, W'(0), 1'b0, acc);
      chk("t4_out_valid", out_valid, 1);
      chk("t4_x_cnt", x_cnt, 0);
      chk("t4_y_cnt", y_cnt, 0);
      cycle(1'b0, W'(0), 1'b1, acc);

      // Random throttling, biased toward uniform samples to exercise runs.
      total = 0;
      cyc   = 0;
      while (total < 1000 && cyc < 20000) begin
         case ($urandom_range(0, 3))
            0:       d = '0;
            1:       d = '1;
            default: d = W'($urandom);
         endcase
         cycle($urandom_range(0, 3) != 0, d, $urandom_range(0, 1) == 1, acc);
         total += int'(acc);
         cyc++;
      end
      if (total < 1000) chk("random_timeout", total, 1000);

      for (int i = 0; i < 4; i++) cycle(1'b0, W'(0), 1'b1, acc);
      @(negedge clk);
      chk("flag_queue_empty", fq.size(), 0);
      chk("report_queue_empty", rq.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
